// File: rtl/display_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync, coordinate and video-enable outputs.
// Optional build macro DTG_FRAME_TICK_EN enables the one-clk frame_tick strobe at the first vertical-blank pixel.
module display_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pix_en,
  output logic       horiz_sync,
  output logic       vert_sync,
  output logic       video_on,
  output logic [9:0] pixel_row,
  output logic [9:0] pixel_column,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Decode thresholds are one bit wider than the counters so a sync region
  // ending exactly at 1024 still compares correctly.
  localparam logic [9:0]  H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_END    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END    = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] hCnt;
  logic [9:0] vCnt;
  logic [9:0] hCntNext;
  logic [9:0] vCntNext;
  logic       hWrap;
  logic       inActive;
  logic       inHSync;
  logic       inVSync;
  logic       hSyncLevel;
  logic       vSyncLevel;

  always_comb begin
    hWrap    = 1'b0;
    hCntNext = hCnt + 10'd1;
    vCntNext = vCnt;
    if (hCnt == H_LAST) begin
      hWrap    = 1'b1;
      hCntNext = 10'd0;
    end
    if (hWrap) begin
      vCntNext = (vCnt == V_LAST) ? 10'd0 : vCnt + 10'd1;
    end
  end

  // Output decode works on the pre-increment counts, so every output lags
  // the counters by exactly one pixel and all outputs stay aligned.
  always_comb begin
    inActive   = ({1'b0, hCnt} < H_ACT_END) && ({1'b0, vCnt} < V_ACT_END);
    inHSync    = ({1'b0, hCnt} >= H_SYNC_START) && ({1'b0, hCnt} < H_SYNC_END);
    inVSync    = ({1'b0, vCnt} >= V_SYNC_START) && ({1'b0, vCnt} < V_SYNC_END);
    hSyncLevel = inHSync ? SYNC_POL : ~SYNC_POL;
    vSyncLevel = inVSync ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hCnt         <= 10'd0;
      vCnt         <= 10'd0;
      pixel_column <= 10'd0;
      pixel_row    <= 10'd0;
      video_on     <= 1'b0;
      horiz_sync   <= ~SYNC_POL;
      vert_sync    <= ~SYNC_POL;
    end else if (pix_en) begin
      hCnt         <= hCntNext;
      vCnt         <= vCntNext;
      pixel_column <= hCnt;
      pixel_row    <= vCnt;
      video_on     <= inActive;
      horiz_sync   <= hSyncLevel;
      vert_sync    <= vSyncLevel;
    end
  end

`ifdef DTG_FRAME_TICK_EN
  logic frameTickReg;

  // Cleared on every clk it is not re-armed, so the strobe lasts one clk
  // even when pix_en is a slow enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frameTickReg <= 1'b0;
    end else begin
      frameTickReg <= pix_en && (hCnt == 10'd0) && ({1'b0, vCnt} == V_ACT_END);
    end
  end

  assign frame_tick = frameTickReg;
`else
  assign frame_tick = 1'b0;
`endif

endmodule

// File: tb/tb_display_timing_gen.sv
// Scoreboard bench for display_timing_gen: a default-timing instance plus a small, inverted-polarity
// instance so whole frames fit in a short run; expectations come from a linear pixel-index model.
module tb_display_timing_gen;

  typedef struct packed {
    logic [9:0] row;
    logic [9:0] col;
    logic       video;
    logic       hs;
    logic       vs;
    logic       ft;
  } pix_t;

  // Small instance geometry: 32 pixels x 19 lines, active-high sync.
  localparam int S_HA = 20, S_HF = 3, S_HS = 5, S_HB = 4;
  localparam int S_VA = 12, S_VF = 2, S_VS = 3, S_VB = 2;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       pixEn = 1'b0;
  logic       hsA, vsA, videoA, ftA, hsB, vsB, videoB, ftB;
  logic [9:0] rowA, colA, rowB, colB;

  int   checks = 0;
  int   errors = 0;
  int   idxA = 0;
  int   idxB = 0;
  int   hsRunA = 0;
  bit   enAtEdge = 1'b0;
  pix_t qA[$];
  pix_t qB[$];
  pix_t lastA, lastB;

  always #5 clk = ~clk;

  display_timing_gen dutA (
    .clk(clk), .reset_n(resetN), .pix_en(pixEn),
    .horiz_sync(hsA), .vert_sync(vsA), .video_on(videoA),
    .pixel_row(rowA), .pixel_column(colA), .frame_tick(ftA)
  );

  display_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .SYNC_POL(1'b1)
  ) dutB (
    .clk(clk), .reset_n(resetN), .pix_en(pixEn),
    .horiz_sync(hsB), .vert_sync(vsB), .video_on(videoB),
    .pixel_row(rowB), .pixel_column(colB), .frame_tick(ftB)
  );

  // The n-th presented pixel since reset is simply pixel n of an endless raster.
  function automatic pix_t model(int idx, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb, bit pol);
    pix_t p;
    int ht = ha + hf + hsw + hb;
    int vt = va + vf + vsw + vb;
    int c = idx % ht;
    int r = (idx / ht) % vt;
    p.col   = 10'(c);
    p.row   = 10'(r);
    p.video = (c < ha) && (r < va);
    p.hs    = (c >= ha + hf && c < ha + hf + hsw) ? pol : ~pol;
    p.vs    = (r >= va + vf && r < va + vf + vsw) ? pol : ~pol;
`ifdef DTG_FRAME_TICK_EN
    p.ft    = (r == va) && (c == 0);
`else
    p.ft    = 1'b0;
`endif
    return p;
  endfunction

  function automatic pix_t resetState(bit pol);
    pix_t p;
    p.row = 10'd0; p.col = 10'd0; p.video = 1'b0;
    p.hs = ~pol; p.vs = ~pol; p.ft = 1'b0;
    return p;
  endfunction

  task automatic cmp(string tag, string field, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d (t=%0t)", tag, field, act, exp, $time);
    end
  endtask

  task automatic checkPix(string tag, pix_t exp, pix_t act);
    cmp(tag, "row", act.row, exp.row);
    cmp(tag, "col", act.col, exp.col);
    cmp(tag, "video_on", act.video, exp.video);
    cmp(tag, "horiz_sync", act.hs, exp.hs);
    cmp(tag, "vert_sync", act.vs, exp.vs);
    cmp(tag, "frame_tick", act.ft, exp.ft);
  endtask

  function automatic pix_t actualA();
    pix_t p;
    p.row = rowA; p.col = colA; p.video = videoA; p.hs = hsA; p.vs = vsA; p.ft = ftA;
    return p;
  endfunction

  function automatic pix_t actualB();
    pix_t p;
    p.row = rowB; p.col = colB; p.video = videoB; p.hs = hsB; p.vs = vsB; p.ft = ftB;
    return p;
  endfunction

  // Stimulus is applied 1 time unit after posedge, so this sees the enable used at the edge.
  always @(posedge clk) enAtEdge = pixEn && resetN;

  always @(negedge clk) begin
    pix_t expA, expB, actA, actB;
    if (!resetN) begin
      hsRunA = 0;
    end else begin
      actA = actualA();
      actB = actualB();
      if (enAtEdge) begin
        if (qA.size() == 0 || qB.size() == 0) begin
          cmp("scoreboard", "queue_empty", 0, 1);
        end else begin
          expA = qA.pop_front();
          expB = qB.pop_front();
          checkPix("pixA", expA, actA);
          checkPix("pixB", expB, actB);
          lastA = expA; lastA.ft = 1'b0;
          lastB = expB; lastB.ft = 1'b0;
          if (actA.hs == 1'b0) begin
            hsRunA++;
          end else if (hsRunA != 0) begin
            cmp("hsyncA", "pulse_width", hsRunA, 96);
            hsRunA = 0;
          end
        end
      end else begin
        checkPix("holdA", lastA, actA);
        checkPix("holdB", lastB, actB);
      end
    end
  end

  // Called at posedge+1: sets the enable for the next edge and predicts its pixel.
  task automatic step(input bit en);
    pixEn = en;
    if (en) begin
      qA.push_back(model(idxA, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
      qB.push_back(model(idxB, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b1));
      idxA++;
      idxB++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(string tag);
    checkPix({tag, "_A"}, resetState(1'b0), actualA());
    checkPix({tag, "_B"}, resetState(1'b1), actualB());
  endtask

  task automatic restartModel();
    qA.delete();
    qB.delete();
    idxA = 0;
    idxB = 0;
    lastA = resetState(1'b0);
    lastB = resetState(1'b1);
  endtask

  initial begin
    restartModel();
    repeat (2) @(posedge clk);
    #7;
    checkReset("power_on_reset");
    resetN = 1'b1;
    @(posedge clk);
    #1;
    $display("phase reset_release: outputs at reset values, checks=%0d", checks);

    for (int i = 0; i < 2000; i++) step(1'b1);
    $display("phase continuous: idxA=%0d idxB=%0d errors=%0d", idxA, idxB, errors);

    for (int i = 0; i < 6000; i++) step(i % 4 == 0);
    $display("phase one_in_four: idxA=%0d idxB=%0d errors=%0d", idxA, idxB, errors);

    for (int i = 0; i < 6000; i++) step($urandom_range(0, 2) != 0);
    $display("phase random: idxA=%0d idxB=%0d errors=%0d", idxA, idxB, errors);

    // Asynchronous reset mid-frame, asserted and released between clock edges.
    pixEn = 1'b0;
    #6;
    resetN = 1'b0;
    #1;
    checkReset("async_reset");
    restartModel();
    @(posedge clk);
    #6;
    resetN = 1'b1;
    @(posedge clk);
    #1;
    $display("phase async_reset: outputs cleared without clock, errors=%0d", errors);

    for (int i = 0; i < 1500; i++) step(1'b1);
    for (int i = 0; i < 3000; i++) step($urandom_range(0, 3) == 0);
    pixEn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp("scoreboard", "leftover_A", qA.size(), 0);
    cmp("scoreboard", "leftover_B", qB.size(), 0);
    $display("phase after_reset: idxA=%0d idxB=%0d errors=%0d", idxA, idxB, errors);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
